// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8-bit UART transmitter with optional parity, timed by a 16x tick divider.
module uart_tx_fsm #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_d,
  output logic       o_tx_busy,
  output logic       o_tx_done
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  generate
    if (DIV < 1) begin : g_div_chk
      $error("uart_tx_fsm: CLK_FREQ too low for BAUD*16");
    end
  endgenerate
  logic [2:0]    state, state_nxt;
  logic [CW-1:0] tick_cnt;
  logic [3:0]    sample_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par, tick, bit_end, accept, tx_nxt;
  assign tick    = tick_cnt == CW'(DIV - 1);
  assign bit_end = tick && sample_cnt == 4'd15;
  assign accept  = state == IDLE && i_tx_start;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? START : IDLE;
      START:   state_nxt = bit_end ? DATA : START;
      DATA:    state_nxt = bit_end && bit_cnt == 3'd7 ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_nxt = bit_end ? STOP : PARITY;
      STOP:    state_nxt = bit_end ? DONE : STOP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Line level is registered from the current state, so it lags the state by one clock.
  assign tx_nxt = state == START  ? 1'b0 :
                  state == DATA   ? shift[0] :
                  state == PARITY ? par : 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      o_tx_d     <= 1'b1;
      o_tx_busy  <= 1'b0;
      o_tx_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_tx_d    <= tx_nxt;
      o_tx_busy <= state != IDLE;
      o_tx_done <= state == DONE;
      if (accept) begin
        shift      <= i_tx_data;
        par        <= ^i_tx_data ^ (PARITY_ODD != 0);
        tick_cnt   <= '0;
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) sample_cnt <= sample_cnt + 4'd1;
        if (bit_end && state == DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

UART transmitter, the transmit-side counterpart to the team's 16x-oversampling UART receiver. It accepts one byte per handshake from the host logic and serializes it onto `o_tx_d` as a standard asynchronous frame: start bit 0, 8 data bits LSB first, optional parity, one stop bit 1. Bit timing comes from an internal 16x tick divider, so the transmitter and receiver share the same timing base (default 115200 baud).

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `PARITY_EN`, default 0: 1 inserts a parity bit between D7 and the stop bit.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.

Ports:
- `clk` in 1: system clock. The block has one clock domain; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i_tx_start` in 1: transmit request. Sampled only while `o_tx_busy`=0.
- `i_tx_data` in 8: byte to send. Captured in the cycle the request is accepted.
- `o_tx_d` out 1: serial line. Registered; idles high.
- `o_tx_busy` out 1: high while a frame is in progress.
- `o_tx_done` out 1: one-cycle pulse when the stop bit completes.

## Operation
- **Divider.** Localparam `DIV` = `CLK_FREQ/(BAUD*16)`, integer-truncated; elaboration must ensure `DIV` >= 1. A tick counter runs 0..`DIV`-1 and asserts `tick` when count = `DIV`-1.
- **Bit width.** `T_BIT` = 16*`DIV` clocks. A 4-bit `sample_cnt` counts ticks within a bit, 0..15; bit end = `tick` && `sample_cnt`==15.
- **Accept.** When `i_tx_start`=1 in IDLE, the block latches `i_tx_data` into a shift register, computes parity from the latched byte, and clears the tick counter, `sample_cnt` and `bit_cnt`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: `o_tx_d`=1. Goes to START on accept.
  - START: `o_tx_d`=0. At bit end, goes to DATA.
  - DATA: `o_tx_d` = shift[0]. At bit end, the register shifts right and `bit_cnt` increments. When `bit_cnt`==7 at bit end, goes to PARITY if `PARITY_EN`, otherwise STOP.
  - PARITY: `o_tx_d` = ^data when `PARITY_ODD`=0, ~^data when `PARITY_ODD`=1. At bit end, goes to STOP.
  - STOP: `o_tx_d`=1. At bit end, goes to DONE.
  - DONE: lasts one cycle, with `o_tx_d`=1, `o_tx_done`=1, `o_tx_busy`=1. Then goes to IDLE.
- **`o_tx_busy`.** Equals (state != IDLE).
- **Requests while busy.** `i_tx_start` asserted while busy, including in DONE, is ignored. There is no queueing.
- **Data changes mid-frame.** Changes on `i_tx_data` during a frame have no effect on the frame.
- **Unused states.** Illegal state encodings go to IDLE.
- **Reset.** On `rst`, the next edge sets state=IDLE, `o_tx_d`=1, `o_tx_busy`=0, `o_tx_done`=0, and clears all counters and the shift register. A reset mid-frame aborts the frame immediately; the line returns high with no done pulse.

## Timing
- Accept at edge k: `o_tx_d` falls at edge k+1.
- Data bit i (0..7) starts at edge k+1+(i+1)·`T_BIT`.
- Parity bit, if enabled, starts at k+1+9·`T_BIT`.
- Stop bit starts at k+1+(9+P)·`T_BIT`, where P = `PARITY_EN`.
- DONE cycle is at k+1+(10+P)·`T_BIT`: `o_tx_done`=1 for exactly one clock. IDLE follows on the next edge.
- Minimum spacing between accepts: (10+P)·`T_BIT`+2 clocks. A start held high continuously is accepted in the first IDLE cycle after DONE.
- Every bit is exactly `T_BIT` clocks, with no cumulative drift inside the divider. Baud error is determined only by the truncation of `DIV`.

## Test plan
Benches use `CLK_FREQ`=1_600_000 and `BAUD`=100_000, giving `DIV`=1 and `T_BIT`=16, unless noted otherwise.
- **Basic frame.** Send 0xA5 with `PARITY_EN`=0. Sampling at each bit centre must give 0,1,0,1,0,0,1,0,1,1. `o_tx_done` pulses at k+161; `o_tx_busy` is high over k+1..k+161.
- **Even parity.** Send 0x00 and 0x07 with `PARITY_EN`=1, `PARITY_ODD`=0. Parity bits must be 0 and 1; done at k+177.
- **Odd parity.** Send 0x01 with `PARITY_EN`=1, `PARITY_ODD`=1. Parity bit must be 0.
- **Back-to-back.** Hold start high with data 0x3C, then 0xC3. The second start bit falls at k+163 and both frames decode correctly.
- **Busy protection.** Pulse start with data 0xFF at k+50 during a 0x12 frame. The line still carries 0x12, only one done pulse occurs, and 0xFF is never sent.
- **Reset mid-frame.** Assert `rst` at k+70 during a 0x55 frame. At the next edge `o_tx_d`=1, busy=0, done=0. A fresh 0x55 sent afterwards transmits correctly.
